display_scanner: RTL and testbench
==================================

# display_scanner

Parametrised time-multiplexed driver for common-anode 7-segment displays, between the value/BCD logic and the board's anode/segment pins. It divides `clk` into per-digit slots and walks a digit select across `NUM_DIGITS` positions. Each slot starts with a dead-time blanking interval to prevent ghosting. It also decodes hex digits, drives decimal points, optionally suppresses leading zeros, and snapshots inputs once per frame so the display never tears.

## Interface
- `NUM_DIGITS`, default 4: digit positions, legal 1..8; digit 0 is least significant.
- `PRESCALE`, default 1000: `clk` cycles per digit slot, legal >= 2.
- `BLANK_CYCLES`, default 16: leading cycles of each slot with all anodes off, legal 0..PRESCALE-1.
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: scan enable; low blanks the display and holds the scan.
- `digits` in 4*NUM_DIGITS: packed nibbles; digit i is `digits[4i+3:4i]`.
- `dp` in NUM_DIGITS: decimal point request per digit, active-high.
- `lz_blank` in 1: leading-zero suppression enable.
- `sel` out SEL_W: index of the digit currently on the pins; SEL_W = max(1, clog2(NUM_DIGITS)).
- `an` out NUM_DIGITS: anode enables, active-low, at most one low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp_n` out 1: decimal point, active-low.
- `frame_tick` out 1: one-cycle pulse at the start of each frame.

## Operation
- Internal `cnt` runs 0..PRESCALE-1. Width is clog2(PRESCALE).
- Internal `idx` runs 0..NUM_DIGITS-1. It advances when `cnt == PRESCALE-1`, wrapping from NUM_DIGITS-1 to 0 (non-power-of-two counts included).
- State machine:
  - OFF: entered on reset or `en` low; `cnt`=0, `idx`=0.
  - OFF→BLANK: on `en` high. The snapshot loads in the same cycle.
  - BLANK: while `cnt < BLANK_CYCLES`; goes to SHOW when `cnt` reaches BLANK_CYCLES.
  - SHOW: goes back to BLANK at the slot wrap.
  - With BLANK_CYCLES=0, BLANK is never occupied.
- Snapshot:
  - `digits`, `dp` and `lz_blank` are copied into internal registers when leaving OFF, and at every wrap from `idx`=NUM_DIGITS-1 to 0.
  - Input changes mid-frame are invisible until the next frame.
- Decode: nibble 0-9 gives the decimal glyph; A-F gives hex glyphs (A,b,C,d,E,F).
- Suppression: digit i is blank when snapshot `lz_blank`=1, i>0, and every snapshot digit from NUM_DIGITS-1 down to i is 0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its anode low and drives `seg`=7'h7F, but its `dp` is still honoured.
- Pins:
  - BLANK or OFF: `an` all ones, `seg`=7'h7F, `dp_n`=1.
  - SHOW: `an` has bit `idx` low, `seg` is the glyph for `idx`, `dp_n` = ~snapshot `dp[idx]`.
- `frame_tick`: high for one cycle when the pins enter slot 0 (first cycle of `idx`=0 BLANK/SHOW). Never high while OFF.

## Timing
- Reset values: `sel`=0, `an`={NUM_DIGITS{1}}, `seg`=7'h7F, `dp_n`=1, `frame_tick`=0, `cnt`=0, `idx`=0, snapshot all zero.
- `sel`, `an`, `seg`, `dp_n` and `frame_tick` are registered. They show the state of the previous cycle, so latency from `cnt`/`idx` to the pins is 1 cycle and `sel` is aligned with `an`.
- `en` rising at edge k: `frame_tick`=1 and slot 0 blanking on the pins from edge k+1.
- `en` falling: pins blank at the next edge. There is no frame completion.
- Slot length is exactly PRESCALE cycles; frame length is NUM_DIGITS*PRESCALE.
- `rst_n` low mid-slot: all state returns to reset values at that edge, and the scan restarts only after `rst_n` is high and `en` is high.
- `en` and the frame wrap in the same cycle: `en` low wins (OFF).

## Structure
- Shared package `display_pkg`:
  - glyph constants SEG_0..SEG_F;
  - SEG_BLANK = 7'h7F;
  - function clog2_min1 for SEL_W.
- Sub-module `hex_to_7seg`: combinational, nibble → active-low pattern. It is instantiated once, on the muxed snapshot digit.
- Top holds the counters, FSM, snapshot, suppression logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.
1. Reset held 3 cycles with `en`=1 → `an`=4'hF, `seg`=7'h7F, `dp_n`=1, `frame_tick`=0 throughout.
2. `digits`=16'h1234, `en`=1 → per 8-cycle slot: 2 blank cycles, then 6 cycles with `an`=4'hE `seg`=7'h19 ("4"), then 4'hD 7'h30, 4'hB 7'h24, 4'h7 7'h79. `frame_tick` every 32 cycles.
3. `digits`=16'h00A0, `lz_blank`=1, `dp`=4'b1000 → digits 3 and 2 show `seg`=7'h7F; digit 3 has `dp_n`=0; digit 1 shows 7'h08 ("A"); digit 0 shows 7'h40 ("0").
4. Change `digits` from 16'h1111 to 16'h2222 mid-frame → current frame shows only "1"s; the next frame shows "2"s starting with its `frame_tick`.
5. Drop `en` during SHOW of digit 2 → blank next cycle. Raising `en` 5 cycles later → `frame_tick`, then slot 0 restarts from blanking.
6. Assert `rst_n`=0 mid-slot for 1 cycle → outputs return to reset values; the scan resumes from digit 0 with count 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the 7-segment display scanner.
package display_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    StOff,
    StBlank,
    StShow
  } scan_state_e;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Full 16-entry decode, lower-case b and d to keep them distinct from 8 and 0.
  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot dead time,
// per-frame input snapshot and optional leading-zero suppression.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned SEL_W       = clog2_min1(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_blank,
  output logic [SEL_W-1:0]        sel,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int unsigned CNT_W = clog2_min1(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(NUM_DIGITS - 1);

  scan_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             snap_load;
  logic             slot_wrap, frame_wrap;

  logic [4*NUM_DIGITS-1:0] snap_digits_q;
  logic [NUM_DIGITS-1:0]   snap_dp_q;
  logic                    snap_lz_q;

  logic [NUM_DIGITS-1:0] suppress;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic [6:0]            glyph;
  logic                  show;

  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  tick_q, tick_d;

  assign slot_wrap  = (cnt_q == CNT_MAX);
  assign frame_wrap = slot_wrap && (idx_q == IDX_MAX);

  // Next-state: counters, FSM and snapshot strobe; en low always forces OFF.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    if (!en) begin
      state_d = StOff;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == StOff) begin
      cnt_d     = '0;
      idx_d     = '0;
      snap_load = 1'b1;
      state_d   = (BLANK_CYCLES > 0) ? StBlank : StShow;
    end else begin
      cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
      if (slot_wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      snap_load = frame_wrap;
      // State tracks the count it will be paired with.
      state_d = (32'(cnt_d) < BLANK_CYCLES) ? StBlank : StShow;
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StOff;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Frame snapshot so mid-frame input changes never tear the display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
    end else if (snap_load) begin
      snap_digits_q <= digits;
      snap_dp_q     <= dp;
      snap_lz_q     <= lz_blank;
    end
  end

  // Leading-zero mask: walk down from the MSD while every digit seen is zero.
  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (snap_digits_q[4*i +: 4] == 4'h0);
      suppress[i] = snap_lz_q && (i > 0) && zero_run;
    end
  end

  assign cur_nib = snap_digits_q[4*int'(idx_q) +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nib),
    .seg    (glyph)
  );

  // Pin values for the next cycle; gated by en so a drop blanks immediately.
  always_comb begin
    show   = en && (state_q == StShow);
    sel_d  = en ? idx_q : '0;
    an_d   = '1;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    tick_d = en && (state_q != StOff) && (idx_q == '0) && (cnt_q == '0);
    if (show) begin
      an_d[idx_q] = 1'b0;
      seg_d       = suppress[idx_q] ? SEG_BLANK : glyph;
      dp_n_d      = ~snap_dp_q[idx_q];
    end
  end

  // Registered pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q  <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
      dp_n_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_n_q <= dp_n_d;
      tick_q <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner: a frame-position model predicts the
// pins after every edge, a monitor compares them on the falling edge.
module tb_display_scanner;

  localparam int N = 4;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, lz_blank;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n, frame_tick;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       tick;
  } pins_t;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  pins_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  display_scanner #(
    .NUM_DIGITS   (N),
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digits     (digits),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .sel        (sel),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: scan described as a position within the frame.
  initial begin : model
    bit          run;
    int          pos, slot, c;
    logic [15:0] s_dig;
    logic [3:0]  s_dp;
    bit          s_lz;
    pins_t       e;
    run = 0; pos = 0; s_dig = '0; s_dp = '0; s_lz = 0;
    forever begin
      @(posedge clk);
      e = '{sel: 2'd0, an: 4'hF, seg: 7'h7F, dp_n: 1'b1, tick: 1'b0};
      if (rst_n && en && run) begin
        slot   = pos / P;
        c      = pos % P;
        e.sel  = 2'(slot);
        e.tick = (pos == 0);
        if (c >= B) begin
          e.an   = ~(4'b0001 << slot);
          e.seg  = (s_lz && slot > 0 && (s_dig >> (4 * slot)) == 16'h0) ? 7'h7F
                 : GLYPH[s_dig[4*slot +: 4]];
          e.dp_n = ~s_dp[slot];
        end
      end
      exp_q.push_back(e);
      if (!rst_n) begin
        run = 0; pos = 0; s_dig = '0; s_dp = '0; s_lz = 0;
      end else if (!en) begin
        run = 0; pos = 0;
      end else if (!run) begin
        run = 1; pos = 0; s_dig = digits; s_dp = dp; s_lz = lz_blank;
      end else begin
        pos = (pos + 1) % (N * P);
        if (pos == 0) begin
          s_dig = digits; s_dp = dp; s_lz = lz_blank;
        end
      end
    end
  end

  // Monitor: pins are presented every cycle; compare against the queue head.
  initial begin : monitor
    pins_t a, e;
    forever begin
      @(negedge clk);
      a = '{sel: sel, an: an, seg: seg, dp_n: dp_n, tick: frame_tick};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got an=%h seg=%h", $time, a.an, a.seg);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pins t=%0t got sel=%0d an=%h seg=%h dp_n=%b tick=%b want sel=%0d an=%h seg=%h dp_n=%b tick=%b",
                   $time, a.sel, a.an, a.seg, a.dp_n, a.tick,
                   e.sel, e.an, e.seg, e.dp_n, e.tick);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int k;
    rst_n = 1'b0; en = 1'b1; digits = '0; dp = '0; lz_blank = 1'b0;
    cyc(3);
    // Basic scan of 1234.
    rst_n = 1'b1; digits = 16'h1234;
    cyc(70);
    // Leading-zero suppression with a dp on a suppressed digit.
    digits = 16'h00A0; lz_blank = 1'b1; dp = 4'b1000;
    cyc(70);
    // Mid-frame change must wait for the next frame.
    digits = 16'h1111; lz_blank = 1'b0; dp = 4'b0000;
    cyc(45);
    digits = 16'h2222;
    cyc(70);
    // Drop en during SHOW of digit 2, then restart.
    k = 0;
    while (!(sel == 2'd2 && an == 4'b1011) && k < 100) begin
      cyc(1);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_show_digit2 got timeout after %0d cycles want an=b", k);
    end
    en = 1'b0;
    cyc(5);
    en = 1'b1;
    cyc(45);
    // One-cycle reset mid-slot.
    cyc(13);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(45);
    // Randomised traffic with occasional en drops and resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        digits   = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
        dp       = 4'($urandom);
        lz_blank = 1'($urandom);
      end
      en    = ($urandom_range(0, 79) != 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    rst_n = 1'b1; en = 1'b1;
    cyc(2);
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
